// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// Pure declarations, no logic.
// No flow control of its own.
package adder_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int MAX_NIBBLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_ci.sv
// 4-bit + 4-bit + carry-in adder; the only arithmetic in the serial adder.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module nibble_add_ci (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // Zero-extend everything to 5 bits so the carry lands in the top bit.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two 4*NIBBLES-bit operands one nibble per clock, LSB nibble first.
// Latency: done pulses NIBBLES+1 cycles after the accepted start; one result per NIBBLES+1 cycles.
// Backpressure: start is only accepted in IDLE or DONE; pulses while busy are dropped, not queued.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4  // legal range 1..MAX_NIBBLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          carry_out
);

    localparam int W     = NIBBLE_W * NIBBLES;
    // Keep the index at least one bit wide so NIBBLES=1 still elaborates.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [W-1:0]       opa;
    logic [W-1:0]       opb;
    logic [W-1:0]       work;
    logic [W-1:0]       next_work;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [NIBBLE_W-1:0] nib_s;
    logic               nib_c;

    nibble_add_ci u_nib (
        .a  (opa[NIBBLE_W-1:0]),
        .b  (opb[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_c)
    );

    // Working result with the current nibble's sum dropped into slot idx.
    always_comb begin
        next_work = work;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                next_work[i*NIBBLE_W +: NIBBLE_W] = nib_s;
            end
        end
    end

    // Control FSM plus operand shifters, index counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            opa       <= '0;
            opb       <= '0;
            work      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Capture operands so later changes on a/b are irrelevant.
                        opa   <= a;
                        opb   <= b;
                        work  <= '0;
                        carry <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry <= nib_c;
                    opa   <= opa >> NIBBLE_W;
                    opb   <= opb >> NIBBLE_W;
                    work  <= next_work;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        // Results publish only here, so sum/carry_out hold otherwise.
                        sum       <= next_work;
                        carry_out <= nib_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: three builds (4, 1 and 16 nibbles) against
// a cycle-count/arithmetic model, plus directed literal expectations.
module tb_nibble_serial_adder;

    localparam int NN [3] = '{4, 1, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st  [3];
    logic [63:0] av  [3];
    logic [63:0] bv  [3];
    logic        bz  [3];
    logic        dn  [3];
    logic        co  [3];
    logic [63:0] smx [3];

    logic [15:0] sm0;
    logic [3:0]  sm1;
    logic [63:0] sm2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) u4 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][15:0]), .b(bv[0][15:0]),
        .busy(bz[0]), .done(dn[0]), .sum(sm0), .carry_out(co[0]));
    nibble_serial_adder #(.NIBBLES(1)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]),
        .busy(bz[1]), .done(dn[1]), .sum(sm1), .carry_out(co[1]));
    nibble_serial_adder #(.NIBBLES(16)) u16 (
        .clk(clk), .rst(rst), .start(st[2]), .a(av[2]), .b(bv[2]),
        .busy(bz[2]), .done(dn[2]), .sum(sm2), .carry_out(co[2]));

    assign smx[0] = {48'd0, sm0};
    assign smx[1] = {60'd0, sm1};
    assign smx[2] = sm2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] wmask(input int n);
        if (n >= 16) return '1;
        return (64'd1 << (4 * n)) - 64'd1;
    endfunction

    // Model: an accepted add occupies NIBBLES cycles, then its result appears
    // with a one-cycle done; starts are taken only when nothing is in flight.
    int          rem  [3];
    logic [64:0] pend [3];
    bit          ed   [3];
    logic [63:0] es   [3];
    bit          ec   [3];
    bit          mvalid = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                rem[i] = 0; ed[i] = 0; es[i] = '0; ec[i] = 0;
            end else if (rem[i] > 0) begin
                rem[i] = rem[i] - 1;
                ed[i]  = (rem[i] == 0);
                if (ed[i]) begin
                    es[i] = pend[i][63:0] & wmask(NN[i]);
                    ec[i] = pend[i][4 * NN[i]];
                end
            end else begin
                ed[i] = 0;
                if (st[i]) begin
                    rem[i]  = NN[i];
                    pend[i] = {1'b0, av[i] & wmask(NN[i])} + {1'b0, bv[i] & wmask(NN[i])};
                end
            end
        end
        mvalid = 1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("n%0d_busy", NN[i]), {63'd0, bz[i]}, {63'd0, rem[i] > 0});
                chk($sformatf("n%0d_done", NN[i]), {63'd0, dn[i]}, {63'd0, ed[i]});
                chk($sformatf("n%0d_sum", NN[i]), smx[i], es[i]);
                chk($sformatf("n%0d_cout", NN[i]), {63'd0, co[i]}, {63'd0, ec[i]});
            end
        end
    end

    // One full addition on instance i with literal expectations for the
    // result and the busy/done timing; optionally scrambles a/b after accept.
    task automatic run_lit(input int i, input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] xs, input logic xc, input bit scr);
        int bcnt = 0;
        int dat  = 0;
        @(negedge clk);
        st[i] = 1'b1; av[i] = x; bv[i] = y;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) st[i] = 1'b0;
            if (scr) begin
                av[i] = {$urandom, $urandom};
                bv[i] = {$urandom, $urandom};
            end
            if (bz[i]) bcnt++;
            if (dn[i] && dat == 0) dat = k;
        end
        chk($sformatf("lit_n%0d_busycycles", NN[i]), 64'(bcnt), 64'(NN[i]));
        chk($sformatf("lit_n%0d_donecycle", NN[i]), 64'(dat), 64'(NN[i] + 1));
        chk($sformatf("lit_n%0d_sum", NN[i]), smx[i], xs);
        chk($sformatf("lit_n%0d_cout", NN[i]), {63'd0, co[i]}, {63'd0, xc});
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; av[i] = '0; bv[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {63'd0, bz[0]}, 64'd0);
        chk("reset_sum", smx[0], 64'd0);

        // Full carry chain, carry ripple, no carries.
        run_lit(0, 64'hFFFF, 64'hFFFF, 64'hFFFE, 1'b1, 0);
        run_lit(0, 64'h0FFF, 64'h0001, 64'h1000, 1'b0, 0);
        run_lit(0, 64'h1234, 64'h4321, 64'h5555, 1'b0, 0);

        // Start while busy is dropped.
        @(negedge clk); st[0] = 1'b1; av[0] = 64'h00F0; bv[0] = 64'h0F10;
        @(negedge clk); st[0] = 1'b0;
        @(negedge clk); st[0] = 1'b1; av[0] = 64'h0001; bv[0] = 64'h0001;
        @(negedge clk); st[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_start_ignored", smx[0], 64'h1000);

        // Back-to-back: start held in the DONE cycle.
        @(negedge clk); st[0] = 1'b1; av[0] = 64'h0100; bv[0] = 64'h0200;
        @(negedge clk); st[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (dn[0]) seen = 1;
        end
        chk("b2b_first_done_seen", {63'd0, seen}, 64'd1);
        st[0] = 1'b1; av[0] = 64'h8000; bv[0] = 64'h8000;
        @(negedge clk); st[0] = 1'b0;
        chk("b2b_no_idle_busy", {63'd0, bz[0]}, 64'd1);
        chk("b2b_first_sum", smx[0], 64'h0300);
        repeat (5) @(negedge clk);
        chk("b2b_sum", smx[0], 64'h0000);
        chk("b2b_cout", {63'd0, co[0]}, 64'd1);

        // Reset in the second RUN cycle, with a start in the same cycle.
        @(negedge clk); st[0] = 1'b1; av[0] = 64'hFFFF; bv[0] = 64'h0001;
        @(negedge clk); st[0] = 1'b0;
        @(negedge clk); rst = 1'b1; st[0] = 1'b1;
        @(negedge clk); rst = 1'b0; st[0] = 1'b0;
        chk("abort_busy", {63'd0, bz[0]}, 64'd0);
        chk("abort_done", {63'd0, dn[0]}, 64'd0);
        chk("abort_sum", smx[0], 64'd0);
        chk("abort_cout", {63'd0, co[0]}, 64'd0);
        repeat (6) @(negedge clk);
        run_lit(0, 64'h0003, 64'h0004, 64'h0007, 1'b0, 0);

        // Operands wiggle during RUN; result follows the captured values.
        run_lit(0, 64'h1111, 64'h2222, 64'h3333, 1'b0, 1);

        // Narrowest and widest builds.
        run_lit(1, 64'hF, 64'hF, 64'hE, 1'b1, 0);
        run_lit(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
